fetcher_prefetch: RTL and testbench

FETCHER_PREFETCH -- requirements
Module: fetcher_prefetch

---
 rtl/fetcher_prefetch.sv | 223 ++++++++++++++++++++++
 tb/tb_fetcher_prefetch.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetcher_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : fetcher_prefetch
// Description : Instruction fetcher with a sequential prefetch FIFO. While
//               enabled, it reads instructions ahead of the core, one request
//               at a time. A core fetch is served from the FIFO head (hit),
//               directly from an arriving response when the FIFO is empty
//               (bypass), or by flushing and re-aiming the stream at the
//               requested PC (miss).
// Ports       : clk, reset_n           - clock, async active-low reset
//               enable                 - allows new prefetch requests
//               core_state, current_pc - core handshake (FETCH / DECODE)
//               mem_read_*             - single-outstanding memory port
//               fetcher_state          - IDLE / FETCHING / FETCHED
//               instruction            - last delivered instruction
//               buffer_count           - valid FIFO entries
// Revision    : 1.0 - initial release
// ============================================================================
module fetcher_prefetch #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int DEPTH                 = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [$clog2(DEPTH):0]           buffer_count
);

    localparam int c_AW    = PROGRAM_MEM_ADDR_BITS;
    localparam int c_DW    = PROGRAM_MEM_DATA_BITS;
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [2:0] c_IDLE     = 3'b000;
    localparam logic [2:0] c_FETCHING = 3'b001;
    localparam logic [2:0] c_FETCHED  = 3'b010;

    localparam logic [2:0] c_CORE_FETCH  = 3'b001;
    localparam logic [2:0] c_CORE_DECODE = 3'b010;

    localparam logic [c_AW-1:0]    c_ADDR_ONE = c_AW'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;

    logic [c_DW-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_AW-1:0]    r_head_addr;
    logic [c_AW-1:0]    r_next_addr;
    logic [c_AW-1:0]    r_req_addr;
    logic               r_outstanding;
    logic               r_stale;
    logic [c_DW-1:0]    r_instruction;

    // ------------------------------------------------------------------------
    // Per-cycle decisions
    // ------------------------------------------------------------------------
    logic w_in_fetch;
    logic w_empty;
    logic w_pc_match;
    logic w_resp;
    logic w_resp_good;
    logic w_hit;
    logic w_bypass;
    logic w_flush;
    logic w_push;
    logic w_pop;
    logic w_issue;

    assign w_in_fetch  = (r_state == c_FETCHING);
    assign w_empty     = (r_count == '0);
    assign w_pc_match  = (r_head_addr == current_pc);
    // A ready is only meaningful while a request is actually outstanding.
    assign w_resp      = r_outstanding && mem_read_ready;
    assign w_resp_good = w_resp && !r_stale;

    assign w_hit    = w_in_fetch && !w_empty && w_pc_match;
    assign w_bypass = w_in_fetch &&  w_empty && w_pc_match && w_resp_good;
    // With an empty buffer and a live request in flight, that request is the
    // head address; wait for it to land before deciding it is a miss.
    assign w_flush  = w_in_fetch && !w_pc_match &&
                      (!w_empty || !r_outstanding || r_stale);

    // Any response arriving during a flush belongs to the abandoned stream.
    assign w_push  = w_resp_good && !w_flush && !w_bypass;
    assign w_pop   = w_hit;
    // Only one request in flight, so the free-slot test reduces to count<DEPTH.
    assign w_issue = enable && !r_outstanding && !w_flush && (r_count < c_FULL);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (core_state == c_CORE_FETCH) w_state_nxt = c_FETCHING;
            end
            c_FETCHING: begin
                // Leaves only when an instruction is actually delivered.
                if (w_hit || w_bypass) w_state_nxt = c_FETCHED;
            end
            c_FETCHED: begin
                if (core_state == c_CORE_DECODE) w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        fetcher_state    = r_state;
        mem_read_valid   = r_outstanding;
        mem_read_address = r_req_addr;
        instruction      = r_instruction;
        buffer_count     = r_count;
    end

    // ------------------------------------------------------------------------
    // FIFO storage (contents need no reset; validity is tracked by r_count)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= mem_read_data;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath and request tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_head_addr   <= '0;
            r_next_addr   <= '0;
            r_req_addr    <= '0;
            r_outstanding <= 1'b0;
            r_stale       <= 1'b0;
            r_instruction <= '0;
        end else begin
            if (w_flush) begin
                r_rd_ptr    <= '0;
                r_wr_ptr    <= '0;
                r_count     <= '0;
                r_head_addr <= current_pc;
                r_next_addr <= current_pc;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;

                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase

                if (w_hit || w_bypass) r_head_addr <= r_head_addr + c_ADDR_ONE;
                // Stale responses do not advance the stream.
                if (w_resp_good)       r_next_addr <= r_next_addr + c_ADDR_ONE;
            end

            if (w_hit) begin
                r_instruction <= r_mem[r_rd_ptr];
            end else if (w_bypass) begin
                r_instruction <= mem_read_data;
            end

            // A flushed request still completes its handshake; remember that
            // its data must be thrown away when it arrives.
            if (w_resp) begin
                r_outstanding <= 1'b0;
                r_stale       <= 1'b0;
            end else if (w_flush && r_outstanding) begin
                r_stale <= 1'b1;
            end

            if (w_issue) begin
                r_outstanding <= 1'b1;
                r_req_addr    <= r_next_addr;
            end
        end
    end

    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (!reset_n) !(w_push && (r_count == c_FULL))
    );

endmodule
`default_nettype wire

// File: tb/tb_fetcher_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetcher_prefetch
// Description : Self-checking bench for fetcher_prefetch. A memory image and
//               responder feed the DUT; expected instructions come from the
//               image, and hit/miss latency is predicted from whether the
//               core's PC continues the stream it last consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetcher_prefetch;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    localparam logic [2:0] ST_IDLE     = 3'b000;
    localparam logic [2:0] ST_FETCHING = 3'b001;
    localparam logic [2:0] ST_FETCHED  = 3'b010;
    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;
    localparam logic [2:0] CORE_OTHER  = 3'b100;

    logic                   clk;
    logic                   reset_n;
    logic                   enable;
    logic [2:0]             core_state;
    logic [AW-1:0]          current_pc;
    logic                   mem_read_valid;
    logic [AW-1:0]          mem_read_address;
    logic                   mem_read_ready;
    logic [DW-1:0]          mem_read_data;
    logic [2:0]             fetcher_state;
    logic [DW-1:0]          instruction;
    logic [$clog2(DEPTH):0] buffer_count;

    fetcher_prefetch #(
        .PROGRAM_MEM_ADDR_BITS (AW),
        .PROGRAM_MEM_DATA_BITS (DW),
        .DEPTH                 (DEPTH)
    ) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .buffer_count     (buffer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image, responder controls and monitor state
    logic [DW-1:0] mem_img [256];
    int            resp_delay;
    bit            resp_hold;
    bit            resp_force;
    int            wait_cnt;
    logic          prev_valid;
    logic          prev_ready;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] issued [$];
    int            peak;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] issued_at(input int i);
        if (i < issued.size()) return 32'(issued[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // One clock: sample at the falling edge, run monitors, then drive memory.
    task automatic tick();
        @(negedge clk);
        if (int'(buffer_count) > peak) peak = int'(buffer_count);
        if (mem_read_valid && (!prev_valid || prev_ready)) issued.push_back(mem_read_address);
        if (mem_read_valid && prev_valid && !prev_ready)
            check_eq("req_hold", 32'(mem_read_address), 32'(prev_addr));
        if (resp_force) begin
            mem_read_ready = 1'b1;
            mem_read_data  = 16'hBAD0;
        end else if (mem_read_ready || !mem_read_valid || resp_hold) begin
            mem_read_ready = 1'b0;
            wait_cnt       = 0;
        end else if (wait_cnt >= resp_delay) begin
            mem_read_ready = 1'b1;
            mem_read_data  = mem_img[mem_read_address];
        end else begin
            wait_cnt++;
        end
        prev_valid = mem_read_valid;
        prev_ready = mem_read_ready;
        prev_addr  = mem_read_address;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        issued.delete();
    endtask

    // Full core transaction: FETCH, wait for FETCHED, DECODE back to IDLE.
    // lat = cycles spent in FETCHING before FETCHED was observed.
    task automatic do_fetch(input logic [AW-1:0] pc, output int lat, output bit done);
        current_pc = pc;
        core_state = CORE_FETCH;
        tick();
        core_state = CORE_OTHER;
        lat  = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            lat++;
            if (fetcher_state == ST_FETCHED) done = 1'b1;
        end
        check_eq("fetch_done", 32'(done), 32'd1);
        core_state = CORE_DECODE;
        tick();
        check_eq("decode_idle", 32'(fetcher_state), 32'(ST_IDLE));
        core_state = 3'b000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            lat;
        bit            done;
        int            n;
        int            gap;
        bit            seq;
        logic [AW-1:0] pc;
        logic [AW-1:0] last;

        n_checks = 0; n_errors = 0; peak = 0;
        reset_n = 1'b0; enable = 1'b0; core_state = 3'b000; current_pc = '0;
        mem_read_ready = 1'b0; mem_read_data = '0;
        resp_delay = 1; resp_hold = 1'b0; resp_force = 1'b0; wait_cnt = 0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_addr = '0;
        for (int i = 0; i < 256; i++) mem_img[i] = 16'(i);

        // ---- reset values
        repeat (3) tick();
        check_eq("rst_state", 32'(fetcher_state),    32'(ST_IDLE));
        check_eq("rst_valid", 32'(mem_read_valid),   32'd0);
        check_eq("rst_addr",  32'(mem_read_address), 32'd0);
        check_eq("rst_instr", 32'(instruction),      32'd0);
        check_eq("rst_count", 32'(buffer_count),     32'd0);

        // ---- idle core fills exactly DEPTH entries from address 0
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (30) tick();
        check_eq("fill_req_count", 32'(issued.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) check_eq("fill_req_addr", issued_at(i), 32'(i));
        check_eq("fill_valid_low", 32'(mem_read_valid), 32'd0);
        check_eq("fill_count",     32'(buffer_count),   32'(DEPTH));

        // ---- sequential stream: every fetch hits with one cycle latency
        for (int p = 0; p < 8; p++) begin
            do_fetch(AW'(p), lat, done);
            check_eq("seq_lat",   32'(lat),         32'd1);
            check_eq("seq_instr", 32'(instruction), 32'(p));
            repeat (12) tick();
        end

        // ---- branch to 0x40: flush, re-aim, bypass
        current_pc = 8'h40;
        core_state = CORE_FETCH;
        tick();
        core_state = CORE_OTHER;
        n = issued.size();
        tick();
        check_eq("branch_flush_cnt", 32'(buffer_count), 32'd0);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (fetcher_state == ST_FETCHED) done = 1'b1;
        end
        check_eq("branch_done",    32'(done),         32'd1);
        check_eq("branch_instr",   32'(instruction),  32'h40);
        check_eq("bypass_no_push", 32'(buffer_count), 32'd0);
        check_eq("branch_req",     issued_at(n),      32'h40);
        core_state = CORE_DECODE;
        tick();
        core_state = 3'b000;

        // ---- stale response: miss to 0x10 while 0x05 is in flight
        mem_img[5] = 16'hDEAD;
        do_reset();
        repeat (20) tick();
        do_fetch(8'h00, lat, done);
        repeat (10) tick();
        resp_hold = 1'b1;
        do_fetch(8'h01, lat, done);
        repeat (4) tick();
        check_eq("stale_pend_valid", 32'(mem_read_valid),   32'd1);
        check_eq("stale_pend_addr",  32'(mem_read_address), 32'h05);
        n = issued.size();
        current_pc = 8'h10;
        core_state = CORE_FETCH;
        tick();
        core_state = CORE_OTHER;
        tick();
        check_eq("stale_flush_cnt", 32'(buffer_count), 32'd0);
        tick();
        tick();
        check_eq("stale_wait_state", 32'(fetcher_state), 32'(ST_FETCHING));
        resp_hold = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (fetcher_state == ST_FETCHED) done = 1'b1;
        end
        check_eq("stale_done",  32'(done),        32'd1);
        check_eq("stale_instr", 32'(instruction), 32'h10);
        check_eq("stale_reaim", issued_at(n),     32'h10);
        core_state = CORE_DECODE;
        tick();
        core_state = 3'b000;
        mem_img[5] = 16'h0005;

        // ---- address wrap-around from 0xFE
        do_reset();
        repeat (20) tick();
        issued.delete();
        do_fetch(8'hFE, lat, done);
        check_eq("wrap_first_miss", 32'(lat > 1),     32'd1);
        check_eq("wrap_instr_fe",   32'(instruction), 32'h00FE);
        for (int k = 0; k < 3; k++) begin
            pc = 8'hFF + AW'(k);
            repeat (12) tick();
            do_fetch(pc, lat, done);
            check_eq("wrap_lat",   32'(lat),         32'd1);
            check_eq("wrap_instr", 32'(instruction), 32'(pc));
        end
        check_eq("wrap_req0", issued_at(0), 32'hFE);
        check_eq("wrap_req1", issued_at(1), 32'hFF);
        check_eq("wrap_req2", issued_at(2), 32'h00);
        check_eq("wrap_req3", issued_at(3), 32'h01);

        // ---- hits still served with enable low; no new requests
        repeat (12) tick();
        enable = 1'b0;
        do_fetch(8'h02, lat, done);
        check_eq("en_off_lat",   32'(lat),         32'd1);
        check_eq("en_off_instr", 32'(instruction), 32'h02);
        repeat (6) tick();
        check_eq("en_off_no_req", 32'(mem_read_valid), 32'd0);
        check_eq("en_off_count",  32'(buffer_count),   32'(DEPTH - 1));
        enable = 1'b1;

        // ---- asynchronous reset between edges while a request is held
        resp_hold = 1'b1;
        repeat (6) tick();
        check_eq("arst_pre_valid", 32'(mem_read_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_state", 32'(fetcher_state),    32'(ST_IDLE));
        check_eq("arst_valid", 32'(mem_read_valid),   32'd0);
        check_eq("arst_addr",  32'(mem_read_address), 32'd0);
        check_eq("arst_instr", 32'(instruction),      32'd0);
        check_eq("arst_count", 32'(buffer_count),     32'd0);
        resp_force = 1'b1;
        enable     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check_eq("late_ready_count", 32'(buffer_count),   32'd0);
        check_eq("late_ready_valid", 32'(mem_read_valid), 32'd0);
        resp_force = 1'b0;
        resp_hold  = 1'b0;
        issued.delete();
        enable = 1'b1;
        repeat (20) tick();
        check_eq("arst_restart_addr", issued_at(0), 32'd0);
        do_fetch(8'h00, lat, done);
        check_eq("arst_restart_lat",   32'(lat),         32'd1);
        check_eq("arst_restart_instr", 32'(instruction), 32'd0);

        // ---- randomized core traffic against the memory image
        for (int i = 0; i < 256; i++) mem_img[i] = 16'($urandom);
        last = 8'h00;
        for (int t = 0; t < 60; t++) begin
            resp_delay = $urandom_range(0, 3);
            gap = $urandom_range(0, 14);
            repeat (gap) tick();
            if ($urandom_range(0, 9) < 7) pc = last + 8'h01;
            else                          pc = 8'($urandom);
            seq = (pc == last + 8'h01);
            do_fetch(pc, lat, done);
            check_eq("rnd_instr", 32'(instruction), 32'(mem_img[pc]));
            if (seq && gap >= 10)  check_eq("rnd_hit_lat",  32'(lat),     32'd1);
            else if (!seq)         check_eq("rnd_miss_lat", 32'(lat > 1), 32'd1);
            last = pc;
        end

        check_eq("peak_count", 32'(peak), 32'(DEPTH));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
